seg7_readback: RTL and testbench
================================

// Module: seg7_readback
//
// PURPOSE
// - Inverse of the hex-to-seven-segment encoder: watches the active-low segment buses that drive
//   the board's HEX displays and reconstructs the displayed hex word.
// - Sits on the display-side nets of the top level. It gives the self-test logic and the debug UART
//   a readback of what the display actually shows.
// - Filters transient patterns and decodes one digit per clock.
// - Presents each new stable display value once, on a valid/ready handshake.
//
// PARAMETERS
// NUM_DIGITS     4   number of 7-segment digits observed (1..8)
// STABLE_CYCLES  4   consecutive identical samples required before a pattern is accepted (>=2)
//
// PORTS
// clk          in   1               system clock, all logic on rising edge
// reset        in   1               synchronous, active-high reset
// seg_in       in   7*NUM_DIGITS    segment buses, digit i at [7*i+6:7*i], bit0=a..bit6=g, active-low
// out_valid    out  1               decoded word available
// out_ready    in   1               consumer accepts word when high with out_valid
// value        out  4*NUM_DIGITS    decoded nibbles, digit i at [4*i+3:4*i]
// blank_mask   out  NUM_DIGITS      bit i set: digit i showed 7'b111_1111 (nibble reads 0)
// err_mask     out  NUM_DIGITS      bit i set: digit i showed a non-hex, non-blank pattern (nibble 0)
//
// BEHAVIOUR
// - Reset (sync, any state, including mid-DECODE):
//   - next edge: state=FILTER, out_valid=0, value=0, blank_mask=0, err_mask=0, stab_cnt=0.
//   - sample register and last_reported load all-ones (all digits blank).
// - Decode table, only these are hex:
//   - 0=100_0000 1=111_1001 2=010_0100 3=011_0000 4=001_1001 5=001_0010 6=000_0010 7=111_1000
//   - 8=000_0000 9=001_1000 A=000_1000 b=000_0011 C=100_0110 d=010_0001 E=000_0110 F=000_1110
// - FILTER:
//   - each edge: sample<=seg_in.
//   - if seg_in!=sample, stab_cnt<=0; else stab_cnt increments, saturating at STABLE_CYCLES-1.
//   - when stab_cnt==STABLE_CYCLES-1, seg_in==sample and sample!=last_reported: snapshot<=sample,
//     clear masks, digit index<=0, go DECODE.
//   - a stable pattern equal to last_reported is never re-reported.
// - DECODE:
//   - one digit per cycle, index 0 first. Writes that digit's nibble and its blank_mask/err_mask bits.
//   - after index NUM_DIGITS-1, go PRESENT.
//   - seg_in is ignored; decoding uses the snapshot only.
// - PRESENT:
//   - out_valid=1. value/blank_mask/err_mask are held stable while out_valid=1 && out_ready=0.
//   - on out_valid&&out_ready: last_reported<=snapshot, out_valid=0 next edge, go FILTER with
//     stab_cnt=0, sample<=seg_in.
//   - seg_in changes during PRESENT are not queued. They are picked up by FILTER afterwards.
//   - out_ready while out_valid=0 has no effect.
// - Latency:
//   - definition: cycle 0 is the first edge at which a new, then constant, seg_in is sampled.
//   - out_valid rises at edge STABLE_CYCLES+NUM_DIGITS+1.
//   - with defaults: edge 9.
// - Outputs are registered; value/masks keep their last word after the handshake until the next DECODE.
// - Widths: all indices sized by $clog2(NUM_DIGITS) and $clog2(STABLE_CYCLES), minimum 1 bit. No truncation warnings.
//
// TESTING
// 1. Reset, seg_in all 7'h7F held 30 cycles -> out_valid stays 0 (matches last_reported).
// 2. Digits3..0 = 1,2,A,F held, out_ready=1 -> out_valid at edge 9, value=16'h12AF, masks 0, pulse one cycle.
// 3. Same as 2 with out_ready=0 for 12 cycles; seg_in switched to "0000" meanwhile ->
//    12AF held stable; after ready, 0000 reported 9 edges later.
// 4. Digit0 toggling 3<->5 every 3 cycles (STABLE_CYCLES=4) -> no out_valid; then hold 5 -> word reported with nibble0=5.
// 5. Digit2=7'b111_1110, digit1=7'h7F, others "8" ->
//    err_mask=4'b0100, blank_mask=4'b0010, value=16'h8008.
// 6. Reset pulsed during DECODE index 2 -> next edge all outputs 0, out_valid 0;
//    same pattern then reported after full latency.

Source files
------------

// File: rtl/seg7_readback_if.sv
// Display readback bus: raw segment buses in, decoded word out on a valid/ready handshake.
// master is the readback block, slave is the consumer that also owns the display nets.
interface seg7_readback_if #(
    parameter int unsigned NUM_DIGITS = 4
) ();
    logic [7*NUM_DIGITS-1:0] seg_in;
    logic                    out_valid;
    logic                    out_ready;
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   blank_mask;
    logic [NUM_DIGITS-1:0]   err_mask;

    modport master (
        input  seg_in,
        input  out_ready,
        output out_valid,
        output value,
        output blank_mask,
        output err_mask
    );

    modport slave (
        output seg_in,
        output out_ready,
        input  out_valid,
        input  value,
        input  blank_mask,
        input  err_mask
    );
endinterface

// File: rtl/seg7_readback.sv
// Reconstructs the hex word shown on active-low 7-segment displays: filters the raw pattern,
// decodes one digit per clock and offers each new stable word once on a valid/ready handshake.
module seg7_readback #(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input logic           clk,
    input logic           reset,
    seg7_readback_if.master bus
);
    localparam int unsigned SegW = 7 * NUM_DIGITS;
    localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned CntW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax  = CntW'(STABLE_CYCLES - 1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {StFilter, StDecode, StPresent} state_e;

    state_e                  state_q, state_d;
    logic [SegW-1:0]         sample_q, sample_d;
    logic [SegW-1:0]         snapshot_q, snapshot_d;
    logic [SegW-1:0]         last_q, last_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [IdxW-1:0]         idx_q, idx_d;
    logic                    valid_q, valid_d;
    logic [4*NUM_DIGITS-1:0] value_q, value_d;
    logic [NUM_DIGITS-1:0]   blank_q, blank_d;
    logic [NUM_DIGITS-1:0]   err_q, err_d;
    logic [5:0]              dec;

    // Returns {err, blank, nibble}; blank and non-hex patterns read as nibble 0.
    function automatic logic [5:0] decode_digit(input logic [6:0] seg);
        case (seg)
            7'b100_0000: return {2'b00, 4'h0};
            7'b111_1001: return {2'b00, 4'h1};
            7'b010_0100: return {2'b00, 4'h2};
            7'b011_0000: return {2'b00, 4'h3};
            7'b001_1001: return {2'b00, 4'h4};
            7'b001_0010: return {2'b00, 4'h5};
            7'b000_0010: return {2'b00, 4'h6};
            7'b111_1000: return {2'b00, 4'h7};
            7'b000_0000: return {2'b00, 4'h8};
            7'b001_1000: return {2'b00, 4'h9};
            7'b000_1000: return {2'b00, 4'hA};
            7'b000_0011: return {2'b00, 4'hB};
            7'b100_0110: return {2'b00, 4'hC};
            7'b010_0001: return {2'b00, 4'hD};
            7'b000_0110: return {2'b00, 4'hE};
            7'b000_1110: return {2'b00, 4'hF};
            7'b111_1111: return 6'b01_0000;
            default:     return 6'b10_0000;
        endcase
    endfunction

    always_comb begin
        state_d    = state_q;
        sample_d   = sample_q;
        snapshot_d = snapshot_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        valid_d    = valid_q;
        value_d    = value_q;
        blank_d    = blank_q;
        err_d      = err_q;
        dec        = decode_digit(snapshot_q[7*idx_q +: 7]);

        unique case (state_q)
            StFilter: begin
                sample_d = bus.seg_in;
                if (bus.seg_in != sample_q) begin
                    cnt_d = '0;
                end else begin
                    if (cnt_q != CntMax) cnt_d = cnt_q + 1'b1;
                    // Only a pattern that differs from the last reported word is re-decoded.
                    if (cnt_q == CntMax && sample_q != last_q) begin
                        snapshot_d = sample_q;
                        blank_d    = '0;
                        err_d      = '0;
                        idx_d      = '0;
                        state_d    = StDecode;
                    end
                end
            end
            StDecode: begin
                value_d[4*idx_q +: 4] = dec[3:0];
                blank_d[idx_q]        = dec[4];
                err_d[idx_q]          = dec[5];
                if (idx_q == IdxLast) state_d = StPresent;
                else                  idx_d   = idx_q + 1'b1;
            end
            StPresent: begin
                if (!valid_q) begin
                    valid_d = 1'b1;
                end else if (bus.out_ready) begin
                    valid_d  = 1'b0;
                    last_d   = snapshot_q;
                    cnt_d    = '0;
                    sample_d = bus.seg_in;
                    state_d  = StFilter;
                end
            end
            default: state_d = StFilter;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StFilter;
            sample_q   <= '1;
            snapshot_q <= '1;
            last_q     <= '1;
            cnt_q      <= '0;
            idx_q      <= '0;
            valid_q    <= 1'b0;
            value_q    <= '0;
            blank_q    <= '0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            sample_q   <= sample_d;
            snapshot_q <= snapshot_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            valid_q    <= valid_d;
            value_q    <= value_d;
            blank_q    <= blank_d;
            err_q      <= err_d;
        end
    end

    assign bus.out_valid  = valid_q;
    assign bus.value      = value_q;
    assign bus.blank_mask = blank_q;
    assign bus.err_mask   = err_q;
endmodule

// File: tb/tb_seg7_readback.sv
// Directed bench for seg7_readback: table of display words plus hand-written sequences for
// back-pressure, glitch filtering and reset during decode.
module tb_seg7_readback;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;

    seg7_readback_if #(.NUM_DIGITS(4)) bus ();

    seg7_readback #(
        .NUM_DIGITS   (4),
        .STABLE_CYCLES(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [27:0] seg;
        logic [15:0] value;
        logic [3:0]  blank;
        logic [3:0]  err;
    } vec_t;

    vec_t tbl[6];

    function automatic logic [6:0] enc(input logic [3:0] n);
        case (n)
            4'h0: return 7'b100_0000;
            4'h1: return 7'b111_1001;
            4'h2: return 7'b010_0100;
            4'h3: return 7'b011_0000;
            4'h4: return 7'b001_1001;
            4'h5: return 7'b001_0010;
            4'h6: return 7'b000_0010;
            4'h7: return 7'b111_1000;
            4'h8: return 7'b000_0000;
            4'h9: return 7'b001_1000;
            4'hA: return 7'b000_1000;
            4'hB: return 7'b000_0011;
            4'hC: return 7'b100_0110;
            4'hD: return 7'b010_0001;
            4'hE: return 7'b000_0110;
            default: return 7'b000_1110;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Number of rising edges until out_valid is seen; -1 if the budget runs out.
    task automatic wait_valid(output int n);
        int k;
        k = 0;
        n = -1;
        while (k < 40) begin
            @(posedge clk);
            #1;
            k++;
            if (bus.out_valid) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int seen;
        bus.seg_in    = '1;
        bus.out_ready = 1'b1;

        tbl[0] = '{"hex_12AF", {enc(4'h1), enc(4'h2), enc(4'hA), enc(4'hF)}, 16'h12AF, 4'b0000, 4'b0000};
        tbl[1] = '{"hex_3456", {enc(4'h3), enc(4'h4), enc(4'h5), enc(4'h6)}, 16'h3456, 4'b0000, 4'b0000};
        tbl[2] = '{"hex_7890", {enc(4'h7), enc(4'h8), enc(4'h9), enc(4'h0)}, 16'h7890, 4'b0000, 4'b0000};
        tbl[3] = '{"hex_BCDE", {enc(4'hB), enc(4'hC), enc(4'hD), enc(4'hE)}, 16'hBCDE, 4'b0000, 4'b0000};
        tbl[4] = '{"err_blank", {enc(4'h8), 7'b111_1110, 7'h7F, enc(4'h8)}, 16'h8008, 4'b0010, 4'b0100};
        tbl[5] = '{"blank3", {7'h7F, 7'h7F, 7'h7F, enc(4'h0)}, 16'h0000, 4'b1110, 4'b0000};

        // Reset and all-blank display: matches last_reported, never reported.
        repeat (3) step();
        reset = 1'b0;
        check("reset_valid", 32'(bus.out_valid), 0);
        check("reset_value", 32'(bus.value), 0);
        check("reset_masks", {bus.blank_mask, bus.err_mask}, 0);
        seen = 0;
        repeat (30) begin
            step();
            if (bus.out_valid) seen++;
        end
        check("blank_no_report", seen, 0);

        for (int i = 0; i < 6; i++) begin
            bus.seg_in = tbl[i].seg;
            wait_valid(n);
            check({tbl[i].name, "_latency"}, n, 10);
            check({tbl[i].name, "_value"}, 32'(bus.value), 32'(tbl[i].value));
            check({tbl[i].name, "_blank"}, 32'(bus.blank_mask), 32'(tbl[i].blank));
            check({tbl[i].name, "_err"}, 32'(bus.err_mask), 32'(tbl[i].err));
            step();
            check({tbl[i].name, "_pulse"}, 32'(bus.out_valid), 0);
            check({tbl[i].name, "_held"}, 32'(bus.value), 32'(tbl[i].value));
            repeat (12) step();
            check({tbl[i].name, "_no_repeat"}, 32'(bus.out_valid), 0);
        end

        // Back-pressure: word held while display changes underneath.
        bus.out_ready = 1'b0;
        bus.seg_in = tbl[0].seg;
        wait_valid(n);
        check("bp_latency", n, 10);
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            if (c == 3) bus.seg_in = {enc(4'h0), enc(4'h0), enc(4'h0), enc(4'h0)};
            step();
            if (!bus.out_valid || bus.value !== 16'h12AF || bus.blank_mask !== 4'b0
                || bus.err_mask !== 4'b0) seen++;
        end
        check("bp_hold", seen, 0);
        bus.out_ready = 1'b1;
        step();
        check("bp_accept", 32'(bus.out_valid), 0);
        wait_valid(n);
        check("bp_next_latency", n, 9);
        check("bp_next_value", 32'(bus.value), 32'h0000);
        step();

        // Glitching digit0 3<->5 every 3 cycles never settles long enough.
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            bus.seg_in = {enc(4'h0), enc(4'h0), enc(4'h0), (i % 2 == 1) ? enc(4'h3) : enc(4'h5)};
            repeat (3) begin
                step();
                if (bus.out_valid) seen++;
            end
        end
        check("toggle_no_valid", seen, 0);
        bus.seg_in = {enc(4'h0), enc(4'h0), enc(4'h0), enc(4'h5)};
        wait_valid(n);
        check("toggle_latency", n, 10);
        check("toggle_value", 32'(bus.value), 32'h0005);
        step();

        // Reset while decoding digit index 2.
        bus.seg_in = tbl[0].seg;
        repeat (7) step();
        reset = 1'b1;
        step();
        check("rst_mid_valid", 32'(bus.out_valid), 0);
        check("rst_mid_value", 32'(bus.value), 0);
        check("rst_mid_masks", {bus.blank_mask, bus.err_mask}, 0);
        reset = 1'b0;
        wait_valid(n);
        check("rst_mid_latency", n, 10);
        check("rst_mid_word", 32'(bus.value), 32'h12AF);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
